// File: rtl/axi_ost_slot_alloc.sv
// axi_ost_slot_alloc: grants the lowest free outstanding-read slot and frees it on the last response beat.
// Latency: alloc handshake -> slot_busy set 1 cycle; freeing beat -> free_valid 1 cycle; alloc_ready/alloc_ptr are combinational from registered state.
// Backpressure: alloc_ready drops while every slot is busy (no same-cycle bypass); response beats count only on resp_valid&&resp_ready.
// Optional build macro AXI_OST_LEN_CHECK_EN adds per-slot burst length tracking reported on err_valid/err_ptr.
module axi_ost_slot_alloc #(
  parameter int OST_DEPTH = 16,
  parameter int LEN_WIDTH = 8,
  localparam int PTR_WIDTH = $clog2(OST_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  input  logic [LEN_WIDTH-1:0] alloc_len,
  output logic                 alloc_ready,
  output logic [PTR_WIDTH-1:0] alloc_ptr,
  input  logic                 resp_valid,
  input  logic                 resp_ready,
  input  logic [PTR_WIDTH-1:0] resp_ptr,
  input  logic                 resp_last,
  output logic [OST_DEPTH-1:0] slot_busy,
  output logic [PTR_WIDTH-1:0] ost_cnt,
  output logic                 free_valid,
  output logic [PTR_WIDTH-1:0] free_ptr,
  output logic                 err_valid,
  output logic [PTR_WIDTH-1:0] err_ptr
);

  logic [OST_DEPTH-1:0] slot_busy_q, slot_busy_d;
  logic [PTR_WIDTH-1:0] ost_cnt_q, ost_cnt_d;
  logic                 free_valid_q;
  logic [PTR_WIDTH-1:0] free_ptr_q;
  logic                 alloc_fire, resp_fire, resp_hit, free_fire;
  logic [OST_DEPTH-1:0] alloc_mask, resp_sel, free_mask;

  // Lowest free slot: scan downward so the lowest zero bit is the last assignment.
  always_comb begin
    alloc_ptr = '0;
    for (int i = OST_DEPTH - 1; i >= 0; i--) begin
      if (!slot_busy_q[i]) alloc_ptr = PTR_WIDTH'(i);
    end
  end

  assign alloc_ready = ~&slot_busy_q;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign resp_fire   = resp_valid & resp_ready;

  // One-hot decodes; an out-of-range resp_ptr decodes to all zeros and touches nothing.
  always_comb begin
    alloc_mask = '0;
    resp_sel   = '0;
    for (int i = 0; i < OST_DEPTH; i++) begin
      alloc_mask[i] = alloc_fire && (alloc_ptr == PTR_WIDTH'(i));
      resp_sel[i]   = (resp_ptr == PTR_WIDTH'(i));
    end
  end

  assign resp_hit  = |(resp_sel & slot_busy_q);
  assign free_fire = resp_fire & resp_last & resp_hit;
  assign free_mask = free_fire ? resp_sel : '0;

  // Next occupancy; alloc and free always hit different slots, so the order of set/clear is irrelevant.
  always_comb begin
    slot_busy_d = (slot_busy_q | alloc_mask) & ~free_mask;
    ost_cnt_d   = ost_cnt_q;
    case ({alloc_fire, free_fire})
      2'b10:   ost_cnt_d = ost_cnt_q + PTR_WIDTH'(1);
      2'b01:   ost_cnt_d = ost_cnt_q - PTR_WIDTH'(1);
      default: ost_cnt_d = ost_cnt_q;
    endcase
  end

  // Occupancy state and the registered free notification; reset drops slots silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_busy_q  <= '0;
      ost_cnt_q    <= '0;
      free_valid_q <= 1'b0;
      free_ptr_q   <= '0;
    end else begin
      slot_busy_q  <= slot_busy_d;
      ost_cnt_q    <= ost_cnt_d;
      free_valid_q <= free_fire;
      if (free_fire) free_ptr_q <= resp_ptr;
    end
  end

  assign slot_busy  = slot_busy_q;
  assign ost_cnt    = ost_cnt_q;
  assign free_valid = free_valid_q;
  assign free_ptr   = free_ptr_q;

`ifdef AXI_OST_LEN_CHECK_EN
  logic [LEN_WIDTH-1:0] len_q [OST_DEPTH];
  logic [LEN_WIDTH-1:0] cnt_q [OST_DEPTH];
  logic [LEN_WIDTH-1:0] sel_len, sel_cnt;
  logic                 err_d;
  logic                 err_valid_q;
  logic [PTR_WIDTH-1:0] err_ptr_q;

  // Stored length and beats-seen count of the slot addressed by the current beat.
  always_comb begin
    sel_len = '0;
    sel_cnt = '0;
    for (int i = 0; i < OST_DEPTH; i++) begin
      if (resp_sel[i]) begin
        sel_len = len_q[i];
        sel_cnt = cnt_q[i];
      end
    end
  end

  // Count holds beats already seen, so the last beat is legal exactly when count == len.
  assign err_d = resp_fire &&
                 (!resp_hit ||
                  ( resp_last && (sel_cnt != sel_len)) ||
                  (!resp_last && (sel_cnt == sel_len)));

  // Per-slot length capture on grant and beat counting that saturates at the stored length.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OST_DEPTH; i++) begin
        len_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      err_valid_q <= 1'b0;
      err_ptr_q   <= '0;
    end else begin
      for (int i = 0; i < OST_DEPTH; i++) begin
        if (alloc_mask[i]) begin
          len_q[i] <= alloc_len;
          cnt_q[i] <= '0;
        end else if (resp_fire && resp_sel[i] && slot_busy_q[i] && (cnt_q[i] != len_q[i])) begin
          cnt_q[i] <= cnt_q[i] + LEN_WIDTH'(1);
        end
      end
      err_valid_q <= err_d;
      if (err_d) err_ptr_q <= resp_ptr;
    end
  end

  assign err_valid = err_valid_q;
  assign err_ptr   = err_ptr_q;
`else
  // Without length tracking the request length is not needed.
  logic unused_len;
  assign unused_len = ^alloc_len;
  assign err_valid  = 1'b0;
  assign err_ptr    = '0;
`endif

endmodule

// File: tb/tb_axi_ost_slot_alloc.sv
// tb_axi_ost_slot_alloc: directed stimulus with a queue scoreboard for grants, frees and errors.
// Latency: outputs sampled on the falling edge or 1 time unit after the rising edge.
// Backpressure: exercises full-occupancy stall, resp_ready low and illegal response beats.
module tb_axi_ost_slot_alloc;

  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic [7:0]    alloc_len;
  logic          alloc_ready;
  logic [PW-1:0] alloc_ptr;
  logic          resp_valid;
  logic          resp_ready;
  logic [PW-1:0] resp_ptr;
  logic          resp_last;
  logic [15:0]   slot_busy;
  logic [PW-1:0] ost_cnt;
  logic          free_valid;
  logic [PW-1:0] free_ptr;
  logic          err_valid;
  logic [PW-1:0] err_ptr;

  int total = 0;
  int bad   = 0;
  int exp_alloc[$];
  int exp_free[$];
  int exp_err[$];

  axi_ost_slot_alloc dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_len(alloc_len),
    .alloc_ready(alloc_ready), .alloc_ptr(alloc_ptr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_ptr(resp_ptr), .resp_last(resp_last),
    .slot_busy(slot_busy), .ost_cnt(ost_cnt),
    .free_valid(free_valid), .free_ptr(free_ptr),
    .err_valid(err_valid), .err_ptr(err_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expectation queues whenever the DUT presents a grant, free or error.
  always @(negedge clk) begin
    if (alloc_valid && alloc_ready) begin
      if (exp_alloc.size() == 0) begin
        total++; bad++;
        $display("FAIL alloc_unexpected: got ptr=%0d want no grant", alloc_ptr);
      end else chk("alloc_ptr", 32'(alloc_ptr), 32'(exp_alloc.pop_front()));
    end
    if (free_valid) begin
      if (exp_free.size() == 0) begin
        total++; bad++;
        $display("FAIL free_unexpected: got ptr=%0d want no free", free_ptr);
      end else chk("free_ptr", 32'(free_ptr), 32'(exp_free.pop_front()));
    end
    if (err_valid) begin
      if (exp_err.size() == 0) begin
        total++; bad++;
        $display("FAIL err_unexpected: got ptr=%0d want no error", err_ptr);
      end else chk("err_ptr", 32'(err_ptr), 32'(exp_err.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc1(input int p, input int len);
    alloc_valid = 1'b1;
    alloc_len   = 8'(len);
    exp_alloc.push_back(p);
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic beat(input int p, input bit last, input bit rdy);
    resp_valid = 1'b1;
    resp_ready = rdy;
    resp_ptr   = PW'(p);
    resp_last  = last;
    tick();
    resp_valid = 1'b0;
    resp_ready = 1'b0;
    resp_last  = 1'b0;
  endtask

  task automatic push_err(input int p);
`ifdef AXI_OST_LEN_CHECK_EN
    exp_err.push_back(p);
`else
    if (p < 0) exp_err.push_back(p);
`endif
  endtask

  initial begin
    rst = 1'b1; alloc_valid = 1'b0; alloc_len = '0;
    resp_valid = 1'b0; resp_ready = 1'b0; resp_ptr = '0; resp_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_slot_busy", 32'(slot_busy), 32'h0);
    chk("rst_ost_cnt", 32'(ost_cnt), 0);
    chk("rst_alloc_ready", 32'(alloc_ready), 1);
    chk("rst_alloc_ptr", 32'(alloc_ptr), 0);
    chk("rst_free_valid", 32'(free_valid), 0);
    chk("rst_free_ptr", 32'(free_ptr), 0);
    chk("rst_err_valid", 32'(err_valid), 0);
    chk("rst_err_ptr", 32'(err_ptr), 0);

    // Three back-to-back grants.
    for (int i = 0; i < 3; i++) alloc1(i, 0);
    chk("b2b_slot_busy", 32'(slot_busy), 32'h0007);
    chk("b2b_ost_cnt", 32'(ost_cnt), 3);

    // Simultaneous grant of slot 3 and free of slot 1.
    alloc_valid = 1'b1; alloc_len = '0; exp_alloc.push_back(3); exp_free.push_back(1);
    resp_valid = 1'b1; resp_ready = 1'b1; resp_ptr = PW'(1); resp_last = 1'b1;
    tick();
    alloc_valid = 1'b0; resp_valid = 1'b0; resp_ready = 1'b0; resp_last = 1'b0;
    chk("sim_slot_busy", 32'(slot_busy), 32'h000D);
    chk("sim_ost_cnt", 32'(ost_cnt), 3);
    chk("sim_free_valid", 32'(free_valid), 1);

    // Illegal beats: non-busy slot, out-of-range slot; then a beat without ready.
    push_err(9);
    beat(9, 1'b1, 1'b1);
    chk("nb_slot_busy", 32'(slot_busy), 32'h000D);
    chk("nb_ost_cnt", 32'(ost_cnt), 3);
    push_err(20);
    beat(20, 1'b1, 1'b1);
    chk("oor_slot_busy", 32'(slot_busy), 32'h000D);
    beat(0, 1'b1, 1'b0);
    chk("nrdy_slot_busy", 32'(slot_busy), 32'h000D);
    chk("nrdy_ost_cnt", 32'(ost_cnt), 3);

    // Fill the remaining slots: 1, then 4..15.
    alloc1(1, 0);
    for (int i = 4; i < 16; i++) alloc1(i, 0);
    chk("full_slot_busy", 32'(slot_busy), 32'hFFFF);
    chk("full_ost_cnt", 32'(ost_cnt), 16);
    chk("full_alloc_ready", 32'(alloc_ready), 0);

    // Free slot 5 while a request waits: no grant in the freeing cycle, slot 5 the cycle after.
    alloc_valid = 1'b1; alloc_len = '0;
    resp_valid = 1'b1; resp_ready = 1'b1; resp_ptr = PW'(5); resp_last = 1'b1;
    exp_free.push_back(5); exp_alloc.push_back(5);
    #1;
    chk("nobypass_alloc_ready", 32'(alloc_ready), 0);
    tick();
    resp_valid = 1'b0; resp_ready = 1'b0; resp_last = 1'b0;
    chk("free5_free_valid", 32'(free_valid), 1);
    chk("free5_alloc_ready", 32'(alloc_ready), 1);
    chk("free5_alloc_ptr", 32'(alloc_ptr), 5);
    chk("free5_ost_cnt", 32'(ost_cnt), 15);
    tick();
    alloc_valid = 1'b0;
    chk("refill_slot_busy", 32'(slot_busy), 32'hFFFF);
    chk("refill_ost_cnt", 32'(ost_cnt), 16);

    // Length checks on slot 7: early last, exact burst, overrun then last.
    exp_free.push_back(7);
    beat(7, 1'b1, 1'b1);
    chk("free7_slot_busy", 32'(slot_busy), 32'hFF7F);
    alloc1(7, 3);
    beat(7, 1'b0, 1'b1);
    exp_free.push_back(7); push_err(7);
    beat(7, 1'b1, 1'b1);
    chk("short_slot_busy", 32'(slot_busy), 32'hFF7F);
    chk("short_ost_cnt", 32'(ost_cnt), 15);
    alloc1(7, 3);
    for (int i = 0; i < 3; i++) beat(7, 1'b0, 1'b1);
    exp_free.push_back(7);
    beat(7, 1'b1, 1'b1);
    chk("exact_slot_busy", 32'(slot_busy), 32'hFF7F);
    alloc1(7, 1);
    beat(7, 1'b0, 1'b1);
    push_err(7);
    beat(7, 1'b0, 1'b1);
    chk("overrun_slot_busy", 32'(slot_busy), 32'hFFFF);
    exp_free.push_back(7);
    beat(7, 1'b1, 1'b1);
    chk("overrun_free_slot_busy", 32'(slot_busy), 32'hFF7F);
    chk("overrun_ost_cnt", 32'(ost_cnt), 15);

    // Reset with four slots busy and a freeing beat in flight: nothing reported.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) alloc1(i, 0);
    chk("four_slot_busy", 32'(slot_busy), 32'h000F);
    chk("four_ost_cnt", 32'(ost_cnt), 4);
    rst = 1'b1;
    resp_valid = 1'b1; resp_ready = 1'b1; resp_ptr = PW'(2); resp_last = 1'b1;
    tick();
    rst = 1'b0; resp_valid = 1'b0; resp_ready = 1'b0; resp_last = 1'b0;
    chk("midrst_slot_busy", 32'(slot_busy), 32'h0);
    chk("midrst_ost_cnt", 32'(ost_cnt), 0);
    chk("midrst_free_valid", 32'(free_valid), 0);
    chk("midrst_alloc_ptr", 32'(alloc_ptr), 0);

    repeat (3) tick();
    chk("alloc_queue_drained", 32'(exp_alloc.size()), 0);
    chk("free_queue_drained", 32'(exp_free.size()), 0);
    chk("err_queue_drained", 32'(exp_err.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_ost_slot_alloc.md
Name: axi_ost_slot_alloc

Overview:
- Outstanding-transaction slot allocator for the AXI read path; upstream of, and paired with, the per-ID response-ordering tracker.
- On each accepted read request it grants the lowest free slot index. That index is the req_ptr handed to the ordering tracker.
- It consumes the tracker's resolved resp_ptr on response beats and frees the slot on the last beat.
- It reports occupancy, the busy bitmap, and a registered free notification.

Parameters:
- OST_DEPTH, 16, number of outstanding slots (indices 0..OST_DEPTH-1).
- LEN_WIDTH, 8, width of the AXI burst length field (beats = len+1).
- PTR_WIDTH, $clog2(OST_DEPTH+1), slot pointer / count width; localparam, not overridable.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- alloc_valid  input  1  request wants a slot.
- alloc_len  input  LEN_WIDTH  AXI len of the request; sampled on the alloc handshake.
- alloc_ready  output  1  a free slot exists.
- alloc_ptr  output  PTR_WIDTH  slot granted on the handshake; lowest free index.
- resp_valid  input  1  response beat valid.
- resp_ready  input  1  response beat accepted downstream.
- resp_ptr  input  PTR_WIDTH  slot the beat belongs to.
- resp_last  input  1  last beat of the burst.
- slot_busy  output  OST_DEPTH  registered occupancy bitmap.
- ost_cnt  output  PTR_WIDTH  registered count of busy slots (0..OST_DEPTH).
- free_valid  output  1  one-cycle pulse: a slot was freed.
- free_ptr  output  PTR_WIDTH  slot freed; valid with free_valid.
- err_valid  output  1  one-cycle pulse: length mismatch (see Optional Feature).
- err_ptr  output  PTR_WIDTH  slot in error; valid with err_valid.

Behaviour:
- Reset values: slot_busy=0, ost_cnt=0, free_valid=0, free_ptr=0, err_valid=0, err_ptr=0, all stored lengths and beat counters=0.
- After reset, alloc_ready=1 and alloc_ptr=0.
- Reset asserted mid-operation drops all slots immediately; no free_valid is emitted for them.
- Allocation:
  - alloc_ready = ~&slot_busy.
  - alloc_ptr = priority-encoded lowest zero bit of slot_busy; combinational from registered state.
  - On alloc_valid&&alloc_ready: slot_busy[alloc_ptr] is set next cycle and alloc_len is stored for that slot.
  - alloc_ptr is stable while alloc_valid is held without ready. It may change only after a handshake or free.
- Free:
  - A beat is accepted when resp_valid&&resp_ready.
  - A freeing beat is an accepted beat with resp_last=1, resp_ptr<OST_DEPTH and slot_busy[resp_ptr]=1.
  - On a freeing beat, slot_busy[resp_ptr] clears next cycle. In that same next cycle, free_valid=1 and free_ptr=resp_ptr.
- Illegal beats: an accepted beat to a non-busy slot, or with resp_ptr>=OST_DEPTH, changes no state.
- No bypass: a slot freed in cycle N is allocatable from cycle N+1. With all slots busy, alloc_ready stays 0 in the freeing cycle.
- Simultaneous alloc and free (always different slots):
  - Both take effect in the same cycle.
  - ost_cnt is net unchanged.
  - Otherwise ost_cnt changes by +1 on alloc only and by -1 on free only.
  - ost_cnt never wraps; it equals the popcount of slot_busy.
- Latency: alloc handshake to slot_busy set is 1 cycle; freeing beat to free_valid is 1 cycle.

Optional Feature:
- Macro: AXI_OST_LEN_CHECK_EN.
- Defined: a per-slot beat counter (LEN_WIDTH bits).
  - The counter is zeroed on allocation and incremented on each accepted beat to a busy slot.
  - resp_last with counter!=stored len raises err_valid/err_ptr next cycle; the slot is still freed.
  - A non-last beat with counter==stored len (overrun) also raises err_valid; the slot stays busy and the counter saturates.
  - A beat to a non-busy or out-of-range slot raises err_valid with err_ptr=resp_ptr.
- Undefined: no counters or length storage; err_valid and err_ptr are tied to 0.

Test Plan:
- Reset, then 3 back-to-back allocs with alloc_valid=1 -> alloc_ptr 0,1,2; slot_busy=0x0007; ost_cnt=3.
- Fill all 16 slots -> alloc_ready=0. Free slot 5 (resp_last=1, resp_ptr=5) -> next cycle free_valid=1, free_ptr=5, alloc_ready=1, alloc_ptr=5.
- Same cycle: alloc (grants slot 3) and freeing beat for slot 1, with slots 0-2 busy -> next cycle slot_busy=0x000D, ost_cnt unchanged at 3.
- Freeing beat to non-busy slot 9 -> no state change, no free_valid. With macro defined: err_valid=1, err_ptr=9.
- Macro defined, alloc_len=3, resp_last on 2nd beat -> err_valid=1 with err_ptr=slot, and the slot is freed. Correct 4-beat burst -> no error.
- rst asserted with 4 slots busy -> next cycle slot_busy=0, ost_cnt=0, no free_valid.
